// File: rtl/hamming_serial_rx.sv
// Receive side of the Hamming(7,4) serial link: deserialises 7-bit codewords,
// corrects single-bit errors and presents the assembled word on a valid/ready port.
module hamming_serial_rx #(
  parameter int WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  output logic                         serial_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             parallel_out,
  output logic [$clog2(WIDTH/4+1)-1:0] err_count,
  output logic                         busy
);

  localparam int BLOCKS = WIDTH / 4;
  localparam int CW     = $clog2(BLOCKS + 1);
  localparam int BW     = $clog2(BLOCKS);
  localparam logic [BW-1:0] LAST_BLK = BW'(BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_q, bit_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic [5:0]        shreg_q, shreg_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]     err_q, err_d;
  logic              ready_q, valid_q, busy_q;

  logic              accept_s;
  logic              last_bit_s;
  logic [6:0]        cw_s;
  logic [2:0]        syn_s;
  logic [3:0]        nib_s;

  // Codeword layout: cw[0]=p1, cw[1]=p2, cw[2]=p3, cw[3..6]=d0..d3; result is {s2,s1,s0}.
  function automatic logic [2:0] syndrome_f(input logic [6:0] cw);
    logic s0, s1, s2;
    s0 = cw[0] ^ cw[6] ^ cw[5] ^ cw[3];
    s1 = cw[1] ^ cw[6] ^ cw[4] ^ cw[3];
    s2 = cw[2] ^ cw[5] ^ cw[4] ^ cw[3];
    return {s2, s1, s0};
  endfunction

  function automatic logic [3:0] correct_f(input logic [6:0] cw, input logic [2:0] syn);
    logic [3:0] d;
    d = cw[6:3];
    case (syn)
      3'b111:  d[0] = ~cw[3];
      3'b110:  d[1] = ~cw[4];
      3'b101:  d[2] = ~cw[5];
      3'b011:  d[3] = ~cw[6];
      default: d = cw[6:3];
    endcase
    return d;
  endfunction

  assign accept_s   = serial_valid & ready_q;
  assign last_bit_s = (bit_q == 3'd6);
  assign cw_s       = {serial_in, shreg_q};
  assign syn_s      = syndrome_f(cw_s);
  assign nib_s      = correct_f(cw_s, syn_s);

  // Next-state logic: frame sequencing, counters, decode write-back and error tally.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    blk_d   = blk_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept_s) begin
      shreg_d = {serial_in, shreg_q[5:1]};
      if (state_q == IDLE) begin
        state_d = RECV;
        err_d   = '0;
      end else begin
        state_d = state_q;
      end
      if (last_bit_s) begin
        bit_d = 3'd0;
        for (int b = 0; b < BLOCKS; b++) begin
          if (blk_q == BW'(b)) begin
            data_d[4*b +: 4] = nib_s;
          end else begin
            data_d[4*b +: 4] = data_q[4*b +: 4];
          end
        end
        if (syn_s != 3'b000) begin
          err_d = err_q + CW'(1);
        end else begin
          err_d = err_q;
        end
        if (blk_q == LAST_BLK) begin
          blk_d   = '0;
          state_d = DONE;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end else begin
        bit_d = bit_q + 3'd1;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      blk_q   <= '0;
      shreg_q <= 6'd0;
      data_q  <= '0;
      err_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      blk_q   <= blk_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ready_q <= (state_d != DONE);
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == RECV);
    end
  end

  assign serial_ready = ready_q;
  assign out_valid    = valid_q;
  assign busy         = busy_q;
  assign parallel_out = data_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: nearest-codeword reference model checked every cycle
// on an 8-bit instance, plus directed frames and a 128-bit all-blocks-corrupted frame.
module tb_hamming_serial_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       serial_in = 1'b0, serial_valid = 1'b0, out_ready = 1'b0;
  logic       serial_ready, out_valid, busy;
  logic [7:0] parallel_out;
  logic [1:0] err_count;

  logic         w_serial_in = 1'b0, w_serial_valid = 1'b0, w_out_ready = 1'b0;
  logic         w_serial_ready, w_out_valid, w_busy;
  logic [127:0] w_parallel_out;
  logic [5:0]   w_err_count;

  hamming_serial_rx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .out_valid(out_valid), .out_ready(out_ready),
    .parallel_out(parallel_out), .err_count(err_count), .busy(busy));

  hamming_serial_rx #(.WIDTH(128)) dut_w (
    .clk(clk), .rst(rst), .serial_in(w_serial_in), .serial_valid(w_serial_valid),
    .serial_ready(w_serial_ready), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .parallel_out(w_parallel_out), .err_count(w_err_count), .busy(w_busy));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit order: index 0..6 = p1,p2,p3,d0,d1,d2,d3.
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[0], d[0]^d[1]^d[2], d[0]^d[1]^d[3], d[0]^d[2]^d[3]};
  endfunction

  // The code is perfect: every 7-bit word lies within distance 1 of exactly one codeword.
  task automatic mdec(input logic [6:0] cw, output logic [3:0] d, output bit bad);
    logic [6:0] c;
    bad = 1'b1;
    d   = 4'h0;
    for (int v = 0; v < 16; v++) begin
      c = enc(4'(v));
      if ($countones(c ^ cw) == 0) begin
        d = 4'(v);
        bad = 1'b0;
      end else if ($countones(c ^ cw) == 1) begin
        d = 4'(v);
      end
    end
  endtask

  bit         m_pend = 1'b0;
  int         m_cnt  = 0;
  int         m_err  = 0;
  logic [7:0] m_data = 8'h00;
  logic [6:0] m_cw   = 7'h00;

  initial begin : model
    logic [3:0] nib;
    bit bad;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pend = 1'b0; m_cnt = 0; m_err = 0; m_data = 8'h00;
      end else if (m_pend) begin
        if (out_ready) m_pend = 1'b0;
      end else if (serial_valid) begin
        if (m_cnt == 0) m_err = 0;
        m_cw[m_cnt % 7] = serial_in;
        m_cnt++;
        if (m_cnt % 7 == 0) begin
          mdec(m_cw, nib, bad);
          m_data[4*((m_cnt/7)-1) +: 4] = nib;
          if (bad) m_err++;
          if (m_cnt == 14) begin
            m_cnt  = 0;
            m_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("serial_ready", serial_ready, !m_pend);
        chk("out_valid", out_valid, m_pend);
        chk("busy", busy, m_cnt != 0);
        chk("parallel_out", parallel_out, m_data);
        chk("err_count", err_count, 128'(m_err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send8(input logic [7:0] data, input logic [13:0] flip, input int gap_pct,
                       input bit rand_rdy, input int nbits);
    logic [13:0] bits;
    logic [6:0] c;
    for (int b = 0; b < 2; b++) begin
      c = enc(data[4*b +: 4]);
      for (int k = 0; k < 7; k++) bits[7*b+k] = c[k];
    end
    bits = bits ^ flip;
    for (int i = 0; i < nbits; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        serial_valid = 1'b0;
        serial_in    = 1'($urandom_range(0, 1));
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      serial_valid = 1'b1;
      serial_in    = bits[i];
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    serial_valid = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic finish8(input logic [7:0] w, input int e, input int hold);
    @(negedge clk);
    chk("done_valid", out_valid, 1'b1);
    chk("done_word", parallel_out, w);
    chk("done_err", err_count, 128'(e));
    for (int i = 0; i < hold; i++) begin
      serial_valid = 1'b1;
      serial_in    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      @(negedge clk);
      chk("bp_ready", serial_ready, 1'b0);
      chk("bp_word", parallel_out, w);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready    = 1'b0;
    serial_valid = 1'b0;
    @(negedge clk);
    chk("hs_valid", out_valid, 1'b0);
    chk("hs_busy", busy, 1'b0);
    chk("hs_word_kept", parallel_out, w);
  endtask

  task automatic chk_reset8();
    chk("rst_ready", serial_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_word", parallel_out, 8'h00);
    chk("rst_err", err_count, 2'd0);
  endtask

  initial begin : main
    logic [3:0]   dn;
    bit           bad;
    logic [7:0]   d, exp_w;
    logic [13:0]  fm;
    logic [6:0]   f;
    int           exp_e, r, p1;
    logic [127:0] wd;
    logic [6:0]   wc;

    chk("model_enc5", enc(4'h5), 7'b0101010);
    chk("model_enca", enc(4'ha), 7'b1010101);
    mdec(7'b1110101, dn, bad);
    chk("model_fix_d2", {bad, dn}, 5'h1a);
    mdec(7'b0101000, dn, bad);
    chk("model_fix_p2", {bad, dn}, 5'h15);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset8();
    chk("rst_w_ready", w_serial_ready, 1'b1);
    chk("rst_w_err", w_err_count, 6'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    send8(8'hA5, 14'h0000, 0, 1'b0, 14);
    finish8(8'hA5, 0, 0);
    send8(8'hA5, 14'h1000, 0, 1'b0, 14);
    finish8(8'hA5, 1, 0);
    send8(8'hA5, 14'h0002, 0, 1'b0, 14);
    finish8(8'hA5, 1, 0);

    send8(8'hA5, 14'h0000, 0, 1'b0, 14);
    finish8(8'hA5, 0, 10);
    send8(8'h3C, 14'h0000, 0, 1'b0, 14);
    finish8(8'h3C, 0, 0);

    send8(8'hA5, 14'h0000, 40, 1'b0, 14);
    finish8(8'hA5, 0, 0);

    send8(8'hA5, 14'h0000, 0, 1'b0, 10);
    rst = 1'b0;
    @(negedge clk);
    chk_reset8();
    @(posedge clk); #1;
    rst = 1'b1;
    send8(8'h5A, 14'h0000, 0, 1'b0, 14);
    finish8(8'h5A, 0, 0);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      exp_e = 0;
      for (int b = 0; b < 2; b++) begin
        f = 7'h00;
        r = $urandom_range(0, 99);
        if (r >= 85) begin
          p1 = $urandom_range(0, 6);
          f[p1] = 1'b1;
          f[(p1 + $urandom_range(1, 6)) % 7] = 1'b1;
        end else if (r >= 50) begin
          f[$urandom_range(0, 6)] = 1'b1;
        end
        fm[7*b +: 7] = f;
        mdec(enc(d[4*b +: 4]) ^ f, dn, bad);
        exp_w[4*b +: 4] = dn;
        exp_e += int'(bad);
      end
      send8(d, fm, 20, 1'b1, 14);
      finish8(exp_w, exp_e, $urandom_range(0, 3));
    end

    wd = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 32; b++) begin
      wc = enc(wd[4*b +: 4]);
      wc[$urandom_range(0, 6)] ^= 1'b1;
      for (int k = 0; k < 7; k++) begin
        w_serial_valid = 1'b1;
        w_serial_in    = wc[k];
        @(posedge clk); #1;
      end
    end
    w_serial_valid = 1'b0;
    @(negedge clk);
    chk("w_valid", w_out_valid, 1'b1);
    chk("w_word", w_parallel_out, wd);
    chk("w_err", w_err_count, 6'd32);
    chk("w_busy", w_busy, 1'b0);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    @(negedge clk);
    chk("w_hs_valid", w_out_valid, 1'b0);
    chk("w_hs_ready", w_serial_ready, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
